nor_flash_ctrl: RTL and testbench
=================================

// Module: nor_flash_ctrl
// PURPOSE
//  Parametrised parallel NOR flash controller: read, program, sector erase, chip erase.
//  Sits between a valid/ready command port and a JEDEC-unlock NOR device; drives a
//  timed reset pulse, generates unlock bus cycles, polls RY/BY# with timeout.
// PARAMETERS
//  ADDR_W      22     flash address width
//  DATA_W      8      flash data width
//  SETUP_CYC   1      cycles address/data stable before nWE/nOE low (>=1)
//  PULSE_CYC   3      nWE/nOE low time in cycles (>=1)
//  RST_CYC     16     flash_nrst low time after rst release
//  BUSY_MIN    20     cycles after last write cycle before RY/BY# is sampled
//  TIMEOUT_CYC 65535  max cycles waiting for RY/BY# high before error
// PORTS
//  clk          in   1       clock
//  rst          in   1       async reset, active-high
//  cmd_valid    in   1       command request
//  cmd_ready    out  1       controller idle, accepts command
//  cmd_op       in   2       0 read, 1 program, 2 sector erase, 3 chip erase
//  cmd_addr     in   ADDR_W  target address (sector address for erase)
//  cmd_wdata    in   DATA_W  program data
//  rsp_valid    out  1       one-cycle completion pulse, every command
//  rsp_rdata    out  DATA_W  read data, held until next read completes
//  rsp_err      out  1       valid with rsp_valid: RY/BY# timeout
//  flash_data   inout DATA_W flash DQ; driven only in write bus cycles
//  flash_address out ADDR_W
//  flash_nce/flash_nwe/flash_noe/flash_nrst  out 1 each, active-low
//  flash_ry_by  in   1       device ready (1) / busy (0), asynchronous
// BEHAVIOUR
//  Reset: nce=nwe=noe=1, nrst=0, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0,
//   flash_data Z, flash_address=0. nrst rises after RST_CYC cycles; cmd_ready then 1.
//  Accept: cmd_valid & cmd_ready at edge T0; op/addr/wdata registered; cmd_ready low
//   until the cycle after rsp_valid. Requests while busy are not accepted.
//  nCE low from T0+1 until return to IDLE; high in IDLE.
//  Write bus cycle: SETUP (SETUP_CYC, addr/data driven, nWE=1) -> WE_LOW (PULSE_CYC)
//   -> HOLD (1 cycle, nWE=1, addr/data still driven). Next cycle follows immediately.
//  Sequences (addr,data), UNLOCK1=0xAAA, UNLOCK2=0x555, zero-extended/truncated:
//   program: (U1,AA)(U2,55)(U1,A0)(addr,wdata)
//   sector erase: (U1,AA)(U2,55)(U1,80)(U1,AA)(U2,55)(addr,30)
//   chip erase: same, last cycle (U1,10)
//  After last HOLD: WAIT_MIN for BUSY_MIN cycles, then POLL on synchronised ry_by
//   (2-flop). High -> DONE. TIMEOUT_CYC POLL cycles without ready -> DONE with err=1.
//  Read: RD_SETUP (SETUP_CYC, addr driven, DQ Z) -> OE_LOW (PULSE_CYC) -> CAPTURE:
//   DQ sampled into rsp_rdata at the CAPTURE edge. noe returns high in CAPTURE.
//   rsp_valid then in DONE. Read latency T0 to rsp_valid = SETUP_CYC+PULSE_CYC+2 cycles.
//  DONE: one cycle, rsp_valid=1; then IDLE. No-read ops leave rsp_rdata unchanged.
//  nWE and nOE are never low together; DQ is never driven while nOE is low.
//  Async rst at any point aborts: all outputs to reset values, flash reset pulse replayed.
//  Counters sized $clog2(max+1); no wrap. TIMEOUT_CYC counter saturates at error.
// STRUCTURE
//  Package nor_flash_pkg: op encodings, command bytes (AA,55,A0,80,30,10),
//   unlock addresses, state enum.
//  Sub-module nor_flash_bus_cycle: one timed write or read cycle (start/done,
//   SETUP/PULSE/HOLD counters, nWE/nOE/DQ-enable). Top holds sequencer
//   (step index + ROM of addr/data per op), busy wait, reset pulse, response regs.
// TESTING
//  Reset: after rst release nrst low exactly 16 cycles, cmd_ready rises next cycle.
//  Read op0 addr 0x12345, model returns 0x5A -> rsp_rdata=0x5A, rsp_err=0, 6 cycles T0 to rsp_valid.
//  Program op1 addr 0x000100 data 0xC3 -> four nWE pulses (AAA/AA,555/55,AAA/A0,100/C3),
//   each 3 cycles low, ry_by low 50 cycles -> rsp_valid, err=0.
//  Sector erase op2 addr 0x10000 -> six cycles ending (10000,30); chip erase ends (AAA,10).
//  ry_by stuck low, TIMEOUT_CYC=100 -> rsp_valid with rsp_err=1 after BUSY_MIN+100 POLL cycles.
//  rst asserted mid WE_LOW -> nwe=1 same cycle (async), DQ Z, new command served after nrst pulse.

Source files
------------

// File: rtl/nor_flash_pkg.sv
// Shared definitions for the NOR flash controller: op codes, JEDEC command
// bytes, unlock addresses and FSM state encodings.
package nor_flash_pkg;

  typedef enum logic [1:0] {
    OP_READ       = 2'd0,
    OP_PROG       = 2'd1,
    OP_SECT_ERASE = 2'd2,
    OP_CHIP_ERASE = 2'd3
  } op_e;

  localparam logic [7:0] CMD_AA = 8'hAA;
  localparam logic [7:0] CMD_55 = 8'h55;
  localparam logic [7:0] CMD_A0 = 8'hA0;
  localparam logic [7:0] CMD_80 = 8'h80;
  localparam logic [7:0] CMD_30 = 8'h30;
  localparam logic [7:0] CMD_10 = 8'h10;

  localparam logic [31:0] UNLOCK1 = 32'h0000_0AAA;
  localparam logic [31:0] UNLOCK2 = 32'h0000_0555;

  typedef enum logic [2:0] {
    ST_RESET, ST_RESET_REL, ST_IDLE, ST_START, ST_BUS, ST_WAIT_MIN, ST_POLL, ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    BC_IDLE, BC_SETUP, BC_PULSE, BC_HOLD, BC_CAPTURE
  } bc_phase_e;

  // Index of the final bus cycle in each op's sequence.
  function automatic logic [2:0] last_step(op_e op);
    case (op)
      OP_READ: return 3'd0;
      OP_PROG: return 3'd3;
      default: return 3'd5;
    endcase
  endfunction

endpackage

// File: rtl/nor_flash_bus_cycle.sv
// One timed flash bus cycle: write (SETUP/WE_LOW/HOLD) or read
// (SETUP/OE_LOW/CAPTURE). A start in the last phase chains the next cycle.
module nor_flash_bus_cycle
  import nor_flash_pkg::*;
#(
  parameter int ADDR_W    = 22,
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              done,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dq_out,
  output logic              dq_oe,
  input  logic [DATA_W-1:0] dq_in,
  output logic              nwe,
  output logic              noe,
  output logic [DATA_W-1:0] rdata
);

  localparam int CNT_MAX = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  bc_phase_e        phase, phase_nx;
  logic [CNT_W-1:0] cnt;
  logic             rd_q;
  logic             accept;

  assign done   = (phase == BC_HOLD) || (phase == BC_CAPTURE);
  assign accept = start && ((phase == BC_IDLE) || done);

  // Strobes decode straight from the phase register so an async reset
  // releases nWE/nOE in the same cycle.
  assign nwe   = !((phase == BC_PULSE) && !rd_q);
  assign noe   = !((phase == BC_PULSE) && rd_q);
  assign dq_oe = !rd_q && ((phase == BC_SETUP) || (phase == BC_PULSE) || (phase == BC_HOLD));

  always_comb begin
    // NOTE: default assigned first so no branch leaves phase_nx unassigned (no latch).
    phase_nx = phase;
    case (phase)
      BC_IDLE:    if (start) phase_nx = BC_SETUP;
      BC_SETUP:   if (cnt == CNT_W'(SETUP_CYC - 1)) phase_nx = BC_PULSE;
      BC_PULSE:   if (cnt == CNT_W'(PULSE_CYC - 1)) phase_nx = rd_q ? BC_CAPTURE : BC_HOLD;
      BC_HOLD,
      BC_CAPTURE: phase_nx = start ? BC_SETUP : BC_IDLE;
      default:    phase_nx = BC_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments for all flop state so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase  <= BC_IDLE;
      cnt    <= '0;
      rd_q   <= 1'b0;
      addr   <= '0;
      dq_out <= '0;
      rdata  <= '0;
    end else begin
      phase <= phase_nx;
      cnt   <= ((phase_nx != phase) || (phase == BC_IDLE)) ? '0 : cnt + 1'b1;
      if (accept) begin
        rd_q   <= rd;
        addr   <= addr_in;
        dq_out <= data_in;
      end
      if ((phase == BC_PULSE) && (phase_nx == BC_CAPTURE)) rdata <= dq_in;
    end
  end

endmodule

// File: rtl/nor_flash_ctrl.sv
// Parallel NOR flash controller: reset pulse, command sequencer with unlock
// ROM, RY/BY# busy wait with timeout, and completion response.
module nor_flash_ctrl
  import nor_flash_pkg::*;
#(
  parameter int ADDR_W      = 22,
  parameter int DATA_W      = 8,
  parameter int SETUP_CYC   = 1,
  parameter int PULSE_CYC   = 3,
  parameter int RST_CYC     = 16,
  parameter int BUSY_MIN    = 20,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  inout  wire  [DATA_W-1:0] flash_data,
  output logic [ADDR_W-1:0] flash_address,
  output logic              flash_nce,
  output logic              flash_nwe,
  output logic              flash_noe,
  output logic              flash_nrst,
  input  logic              flash_ry_by
);

  localparam int CNT_MAX0 = (RST_CYC > BUSY_MIN) ? RST_CYC : BUSY_MIN;
  localparam int CNT_MAX  = (CNT_MAX0 > TIMEOUT_CYC) ? CNT_MAX0 : TIMEOUT_CYC;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [ADDR_W-1:0] U1_ADDR = ADDR_W'(UNLOCK1);
  localparam logic [ADDR_W-1:0] U2_ADDR = ADDR_W'(UNLOCK2);

  state_e            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  op_e               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        step, rom_step;
  logic              err_q;
  logic [1:0]        ry_sync;
  logic              accept, bus_start, bus_done, bus_rd, last_cycle, dq_oe;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data, dq_out;

  assign cmd_ready  = (state == ST_IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign bus_rd     = (op_q == OP_READ);
  assign last_cycle = (step == last_step(op_q));
  assign rom_step   = (state == ST_BUS) ? step + 3'd1 : 3'd0;
  assign bus_start  = (state == ST_START) || ((state == ST_BUS) && bus_done && !last_cycle);

  assign flash_nrst = (state != ST_RESET);
  assign flash_nce  = !((state == ST_BUS) || (state == ST_WAIT_MIN) ||
                        (state == ST_POLL) || (state == ST_DONE));
  assign rsp_valid  = (state == ST_DONE);
  assign rsp_err    = rsp_valid && err_q;
  assign flash_data = dq_oe ? dq_out : 'z;

  // Address/data ROM for the bus cycle about to start.
  always_comb begin
    rom_addr = U1_ADDR;
    rom_data = DATA_W'(CMD_AA);
    case (op_q)
      OP_READ: rom_addr = addr_q;
      OP_PROG:
        case (rom_step)
          3'd0:    rom_data = DATA_W'(CMD_AA);
          3'd1:    begin rom_addr = U2_ADDR; rom_data = DATA_W'(CMD_55); end
          3'd2:    rom_data = DATA_W'(CMD_A0);
          default: begin rom_addr = addr_q; rom_data = wdata_q; end
        endcase
      default:
        case (rom_step)
          3'd0, 3'd3: rom_data = DATA_W'(CMD_AA);
          3'd1, 3'd4: begin rom_addr = U2_ADDR; rom_data = DATA_W'(CMD_55); end
          3'd2:       rom_data = DATA_W'(CMD_80);
          default:
            if (op_q == OP_SECT_ERASE) begin
              rom_addr = addr_q;
              rom_data = DATA_W'(CMD_30);
            end else begin
              rom_data = DATA_W'(CMD_10);
            end
        endcase
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_RESET:     if (cnt == CNT_W'(RST_CYC - 1)) state_nx = ST_RESET_REL;
      ST_RESET_REL: state_nx = ST_IDLE;
      ST_IDLE:      if (cmd_valid) state_nx = ST_START;
      ST_START:     state_nx = ST_BUS;
      ST_BUS:       if (bus_done && last_cycle) state_nx = bus_rd ? ST_DONE : ST_WAIT_MIN;
      ST_WAIT_MIN:  if (cnt == CNT_W'(BUSY_MIN - 1)) state_nx = ST_POLL;
      ST_POLL:      if (ry_sync[1] || (cnt == CNT_W'(TIMEOUT_CYC - 1))) state_nx = ST_DONE;
      default:      state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_RESET;
      cnt     <= '0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      step    <= '0;
      err_q   <= 1'b0;
      ry_sync <= '0;
    end else begin
      state   <= state_nx;
      // Counts cycles spent in a timed state; cleared on every state change.
      cnt     <= ((state_nx == state) && ((state == ST_RESET) || (state == ST_WAIT_MIN) ||
                  (state == ST_POLL))) ? cnt + 1'b1 : '0;
      ry_sync <= {ry_sync[0], flash_ry_by};
      if (accept) begin
        op_q    <= op_e'(cmd_op);
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        step    <= '0;
        err_q   <= 1'b0;
      end else if ((state == ST_BUS) && bus_start) begin
        step <= step + 3'd1;
      end
      if ((state == ST_POLL) && (state_nx == ST_DONE) && !ry_sync[1]) err_q <= 1'b1;
    end
  end

  nor_flash_bus_cycle #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .SETUP_CYC(SETUP_CYC),
    .PULSE_CYC(PULSE_CYC)
  ) u_bus (
    .clk    (clk),
    .rst    (rst),
    .start  (bus_start),
    .rd     (bus_rd),
    .addr_in(rom_addr),
    .data_in(rom_data),
    .done   (bus_done),
    .addr   (flash_address),
    .dq_out (dq_out),
    .dq_oe  (dq_oe),
    .dq_in  (flash_data),
    .nwe    (flash_nwe),
    .noe    (flash_noe),
    .rdata  (rsp_rdata)
  );

endmodule

// File: tb/tb_nor_flash_ctrl.sv
// Self-checking bench for nor_flash_ctrl: scoreboarded bus cycles and
// responses against a small behavioural NOR device model.
module tb_nor_flash_ctrl;

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [7:0]  data;
  } bus_t;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         lat;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [21:0] cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  wire  [7:0]  flash_data;
  logic [21:0] flash_address;
  logic        flash_nce, flash_nwe, flash_noe, flash_nrst;
  wire         flash_ry_by;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          t0 = 0;
  bus_t        exp_bus[$];
  rsp_t        exp_rsp[$];

  logic [7:0]  model_byte = 8'h00;
  logic        stuck = 1'b0;
  int          busy = 0;
  logic        prev_nwe = 1'b1;

  int          pulse_len = 0;
  int          overlap = 0;
  logic        pulse_rd = 1'b0;
  logic [31:0] pulse_addr = '0;
  logic [7:0]  pulse_data = '0;

  nor_flash_ctrl #(.TIMEOUT_CYC(100)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .flash_data   (flash_data),
    .flash_address(flash_address),
    .flash_nce    (flash_nce),
    .flash_nwe    (flash_nwe),
    .flash_noe    (flash_noe),
    .flash_nrst   (flash_nrst),
    .flash_ry_by  (flash_ry_by)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Device model: drives DQ while nOE low, busy for 50 cycles after each nWE rise.
  assign flash_data  = !flash_noe ? model_byte : 8'hzz;
  assign flash_ry_by = !stuck && (busy == 0);

  always @(negedge clk) begin
    prev_nwe <= flash_nwe;
    if (rst) busy <= 0;
    else if (flash_nwe && !prev_nwe) busy <= 50;
    else if (busy > 0) busy <= busy - 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus-cycle monitor: one scoreboard entry per nWE or nOE pulse.
  always @(negedge clk) begin
    if (rst) begin
      pulse_len <= 0;
      overlap   <= 0;
    end else if (!flash_nwe || !flash_noe) begin
      pulse_len  <= pulse_len + 1;
      pulse_rd   <= !flash_noe;
      pulse_addr <= 32'(flash_address);
      pulse_data <= flash_data;
      if (!flash_nwe && !flash_noe) overlap <= overlap + 1;
    end else if (pulse_len != 0) begin
      pulse_len <= 0;
      overlap   <= 0;
      if (exp_bus.size() == 0) begin
        check("unexpected_bus_cycle", pulse_addr, 32'hFFFF_FFFF);
      end else begin
        bus_t e;
        e = exp_bus.pop_front();
        check("bus_kind_rd", 32'(pulse_rd), 32'(e.rd));
        check("bus_addr", pulse_addr, e.addr);
        check("pulse_len", 32'(pulse_len), 32'd3);
        check("we_oe_overlap", 32'(overlap), 32'd0);
        if (!e.rd) check("we_data", 32'(pulse_data), 32'(e.data));
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_rsp.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_rdata), 32'hFFFF_FFFF);
      end else begin
        rsp_t r;
        r = exp_rsp.pop_front();
        check("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
        check("rsp_err", 32'(rsp_err), 32'(r.err));
        if (r.lat >= 0) check("rsp_latency", 32'(cyc - t0), 32'(r.lat));
      end
    end
  end

  task automatic push_bus(input bit rd, input logic [31:0] a, input logic [7:0] d);
    bus_t e;
    e.rd = rd; e.addr = a; e.data = d;
    exp_bus.push_back(e);
  endtask

  task automatic release_reset();
    int n = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    while (!flash_nrst && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("nrst_low_cycles", 32'(n), 32'd16);
    check("ready_at_nrst_rise", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("ready_after_nrst", 32'(cmd_ready), 32'd1);
  endtask

  task automatic issue(input logic [1:0] op, input logic [21:0] addr, input logic [7:0] wdata,
                       input logic [7:0] exp_rdata, input logic exp_err, input int exp_lat);
    int   n = 0;
    rsp_t r;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("ready_before_cmd", 32'(cmd_ready), 32'd1);
    case (op)
      2'd0: push_bus(1'b1, 32'(addr), 8'h00);
      2'd1: begin
        push_bus(1'b0, 32'hAAA, 8'hAA); push_bus(1'b0, 32'h555, 8'h55);
        push_bus(1'b0, 32'hAAA, 8'hA0); push_bus(1'b0, 32'(addr), wdata);
      end
      default: begin
        push_bus(1'b0, 32'hAAA, 8'hAA); push_bus(1'b0, 32'h555, 8'h55);
        push_bus(1'b0, 32'hAAA, 8'h80); push_bus(1'b0, 32'hAAA, 8'hAA);
        push_bus(1'b0, 32'h555, 8'h55);
        if (op == 2'd2) push_bus(1'b0, 32'(addr), 8'h30);
        else            push_bus(1'b0, 32'hAAA, 8'h10);
      end
    endcase
    r.rdata = exp_rdata; r.err = exp_err; r.lat = exp_lat;
    exp_rsp.push_back(r);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wdata;
    @(posedge clk);
    #1;
    t0 = cyc;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("busy_not_ready", 32'(cmd_ready), 32'd0);
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (exp_rsp.size() != 0 && n < 400) begin
      n++;
      @(negedge clk);
    end
    check("rsp_received", 32'(exp_rsp.size()), 32'd0);
    check("bus_cycles_all_seen", 32'(exp_bus.size()), 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_nce", 32'(flash_nce), 32'd1);
    check("rst_nwe", 32'(flash_nwe), 32'd1);
    check("rst_noe", 32'(flash_noe), 32'd1);
    check("rst_nrst", 32'(flash_nrst), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_addr", 32'(flash_address), 32'd0);
    release_reset();

    model_byte = 8'h5A;
    issue(2'd0, 22'h012345, 8'h00, 8'h5A, 1'b0, 6);
    wait_rsp();

    issue(2'd1, 22'h000100, 8'hC3, 8'h5A, 1'b0, -1);
    wait_rsp();

    issue(2'd2, 22'h010000, 8'h00, 8'h5A, 1'b0, -1);
    wait_rsp();

    issue(2'd3, 22'h000000, 8'h00, 8'h5A, 1'b0, -1);
    wait_rsp();

    // RY/BY# stuck busy: 1 launch + 4 bus cycles of 5 + BUSY_MIN 20 + 100 polls.
    stuck = 1'b1;
    issue(2'd1, 22'h002000, 8'h11, 8'h5A, 1'b1, 141);
    wait_rsp();
    stuck = 1'b0;

    model_byte = 8'hA5;
    issue(2'd0, 22'h3FFFFF, 8'h00, 8'hA5, 1'b0, 6);
    wait_rsp();

    // Abort a program in the middle of its first WE_LOW.
    issue(2'd1, 22'h000055, 8'h77, 8'hA5, 1'b0, -1);
    n = 0;
    while (flash_nwe && n < 50) begin
      n++;
      @(negedge clk);
    end
    @(negedge clk);
    check("we_low_before_rst", 32'(flash_nwe), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("abort_nwe", 32'(flash_nwe), 32'd1);
    check("abort_nce", 32'(flash_nce), 32'd1);
    check("abort_nrst", 32'(flash_nrst), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd0);
    check("abort_rdata", 32'(rsp_rdata), 32'd0);
    exp_bus.delete();
    exp_rsp.delete();
    repeat (2) @(posedge clk);
    release_reset();

    model_byte = 8'h3C;
    issue(2'd0, 22'h000000, 8'h00, 8'h3C, 1'b0, 6);
    wait_rsp();

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
